// File: rtl/parallel_serial_tx_pkg.sv
// Shared types and constants for the byte-to-serial transmit lane.
package parallel_serial_tx_pkg;

    localparam int BYTE_W = 8;

    // Default comma/idle byte (K28.5 payload).
    localparam logic [BYTE_W-1:0] IDLE_CHAR_DEF = 8'hBC;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_e;

endpackage

// File: rtl/parallel_serial_tx_if.sv
// Byte handshake and serial output bundle between the word splitter and the transmitter.
interface parallel_serial_tx_if;
    import parallel_serial_tx_pkg::*;

    logic              valid_in;
    logic [BYTE_W-1:0] data_in;
    logic              byte_ready;
    logic              sync_done;
    logic              data_out;

    modport master (
        output valid_in, data_in,
        input  byte_ready, sync_done, data_out
    );

    modport slave (
        input  valid_in, data_in,
        output byte_ready, sync_done, data_out
    );
endinterface

// File: rtl/parallel_serial_tx_bit_counter.sv
// Free-running 3-bit bit-position counter; flags the load edge at count 7.
module tx_bit_counter (
    input  logic       clk_32f,
    input  logic       reset,
    output logic [2:0] bit_cnt,
    output logic       load
);

    // Wraps 7 -> 0 naturally; one byte slot every 8 cycles.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) bit_cnt <= 3'd0;
        else       bit_cnt <= bit_cnt + 3'd1;
    end

    assign load = (bit_cnt == 3'd7);

endmodule

// File: rtl/parallel_serial_tx.sv
// Byte-wide to serial transmitter: MSB first, commas during sync and on idle slots.
module parallel_serial_tx
    import parallel_serial_tx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_CHAR  = IDLE_CHAR_DEF,
    parameter int                SYNC_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    parallel_serial_tx_if.slave  tx
);

    localparam int                CNT_W     = $clog2(SYNC_COUNT + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT);
    // The byte preloaded at reset is already the first comma.
    localparam logic [CNT_W-1:0] COMMA_RST = CNT_W'(1);

    tx_state_e         state, state_nxt;
    logic [CNT_W-1:0]  comma_cnt, comma_nxt;
    logic [BYTE_W-1:0] shift_reg, load_byte;
    logic [2:0]        bit_cnt;
    logic              load;
    logic              accept;

    tx_bit_counter u_bit_counter (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bit_cnt (bit_cnt),
        .load    (load)
    );

    // A byte slot is offered upstream once sync has sent its last comma.
    assign accept = (bit_cnt == 3'd7) && (state == ST_ACTIVE || comma_cnt == SYNC_LAST);

    // Next-state and load-byte selection; commas are forced until the slot is accepted.
    always_comb begin
        state_nxt = state;
        comma_nxt = comma_cnt;
        load_byte = IDLE_CHAR;
        if (load) begin
            if (accept) begin
                state_nxt = ST_ACTIVE;
                if (tx.valid_in) load_byte = tx.data_in;
            end else begin
                comma_nxt = comma_cnt + 1'b1;
            end
        end
    end

    // State and comma counter registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= ST_SYNC;
            comma_cnt <= COMMA_RST;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_nxt;
        end
    end

    // Shift out MSB first; reload on the slot boundary so there is no bubble.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset)     shift_reg <= IDLE_CHAR;
        else if (load) shift_reg <= load_byte;
        else           shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
    end

    assign tx.byte_ready = accept;
    assign tx.sync_done  = (state == ST_ACTIVE);
    assign tx.data_out   = shift_reg[BYTE_W-1];

endmodule

// File: doc/parallel_serial_tx.md
# parallel_serial_tx

Byte-wide to serial transmitter that sits directly downstream of the 32b→8b word splitter in the transmit lane. It accepts one byte every 8 cycles of `clk_32f` and shifts it out MSB first, one bit per cycle. It emits a programmable comma/idle character during link synchronisation and whenever no valid byte is offered.

## Interface
- `IDLE_CHAR`, 8'hBC; comma/idle byte (K28.5 payload) sent during sync and when `valid_in` is low.
- `SYNC_COUNT`, 4; number of comma bytes sent after reset before data is accepted; legal range ≥1.

- `clk_32f`  input  1  single clock, bit rate; all state on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `valid_in`  input  1  upstream byte valid, sampled only on a load edge.
- `data_in`  input  8  upstream byte, sampled with `valid_in`.
- `byte_ready`  output  1  high in the cycle whose closing edge samples `data_in`/`valid_in`.
- `sync_done`  output  1  high once in ACTIVE state.
- `data_out`  output  1  serial bit, equals `shift_reg[7]`.

## Operation
- `bit_cnt` is 3 bits, free-running 0..7 with wrap to 0. A load edge is any rising edge where `bit_cnt`==7.
- On every non-load edge, `shift_reg` shifts left by 1 with 0 fill.
- States:
  - SYNC: on a load edge with `comma_cnt` < `SYNC_COUNT`, load `IDLE_CHAR` and increment `comma_cnt`. On a load edge with `comma_cnt`==`SYNC_COUNT`, go to ACTIVE and apply the ACTIVE load rule on that same edge.
  - ACTIVE: on a load edge, load `data_in` if `valid_in`, else load `IDLE_CHAR`. ACTIVE is left only by reset.
- `comma_cnt` width is $clog2(`SYNC_COUNT`+1). Its reset value is 1, because the byte preloaded at reset counts as the first comma. It saturates and does not wrap.
- `byte_ready` = (`bit_cnt`==7) && (state==ACTIVE || `comma_cnt`==`SYNC_COUNT`). It is never asserted on a load edge that forces a comma.
- `valid_in`/`data_in` are ignored on every edge except load edges where `byte_ready` is high.
- Reset values:
  - `bit_cnt`=0, state=SYNC, `comma_cnt`=1, `shift_reg`=`IDLE_CHAR`.
  - `data_out`=`IDLE_CHAR`[7] (1 for 8'hBC), `byte_ready`=0, `sync_done`=0.
- Reset asserted mid-byte: the partial byte is dropped, outputs return to reset values without waiting for a clock edge, and the full sync sequence restarts after release.

## Timing
- Edge numbering: edge n is the n-th rising edge after `reset` falls. Load edges are edges 8k, k≥1.
- Bit timing: the byte loaded at edge E drives bit 7 on `data_out` from E until E+1, then bit 6 until E+2, and so on. Bit 0 appears in the cycle before edge E+8.
- Latency from sample to first serial bit is 0 cycles after the load edge.
- With `SYNC_COUNT`=4:
  - Comma bytes occupy edges 0–32.
  - `byte_ready` is first high in the cycle before edge 32.
  - `sync_done` rises at edge 32.
  - The first data byte is serialised from edge 32.
- Throughput: one byte per 8 cycles, with no bubbles between bytes.
- The upstream block must hold `data_in` stable through each load edge. `byte_ready` is a strobe, not a backpressure signal.

## Structure
- Shared package holds:
  - the state enum (SYNC, ACTIVE);
  - the default `IDLE_CHAR` constant 8'hBC;
  - the byte width constant 8.
- One sub-module is natural: `tx_bit_counter`, a 3-bit wrap counter with async reset that outputs `bit_cnt` and a `load` flag.
- Load-select, the shift register and the FSM stay flat in the top.

## Test plan
- Reset check: hold `reset`=1 and toggle the clock.
  - Required: `data_out`=1, `byte_ready`=0, `sync_done`=0.
  - Assert `reset` mid-cycle and confirm outputs change without a clock edge.
- Sync sequence: release reset with `valid_in`=1, `data_in`=8'hFF.
  - Required: `data_out` for edges 0–32 is 10111100 repeated four times.
  - Required: `byte_ready` is first high in the cycle before edge 32, and `sync_done` rises at edge 32.
  - Required: 11111111 follows.
- Back-to-back data: after sync, present 8'hFF, 8'hAA, 8'hFF, 8'hBB on consecutive `byte_ready` strobes.
  - Required serial stream: 11111111 10101010 11111111 10111011, no gaps.
- Idle insertion: after sync, drive `valid_in`=0 for 2 load edges, then `valid_in`=1 with 8'h03.
  - Required: 10111100 10111100 00000011.
- Mid-byte reset: assert `reset` 3 cycles into the 8'hAA byte and release.
  - Required: the remaining AA bits are never emitted.
  - Required: four commas are re-sent and `sync_done` stays 0 until edge 32.
- Parameter sweep: `SYNC_COUNT`=1, `IDLE_CHAR`=8'h7C.
  - Required: one 01111100 byte, then `byte_ready` in the cycle before edge 8, and data from edge 8.
